keypad_scanner: RTL and testbench

- Scans a 4x4 passive keypad, the input-side counterpart of the 8x8 dot-matrix scan driver.
- Drives one active-low column at a time and samples the four active-low, pulled-up row lines.
- Debounces across whole scans and presents one key code per debounced press through a valid/ack holding register.
- Runs on the divided clock alongside the display driver.

---
 rtl/keypad_pkg.sv | 53 +++++
 rtl/keypad_debounce.sv | 72 +++++++
 rtl/keypad_scanner.sv | 109 ++++++++++
 tb/tb_keypad_scanner.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and helpers for the 4x4 keypad scanner.
//   NUM_ROWS / NUM_COLS : keypad geometry
//   scan_kind_t         : classification of one full scan (NONE / SINGLE / MULTI)
//   key_code_t          : 4-bit key code, col_idx*4 + row_idx
//   scan_result_t       : kind plus code (code is 0 unless kind is SINGLE)
//   COL_DRIVE           : active-low one-hot column drive pattern per column index
//   classify()          : turns a 16-bit active-low snapshot into a scan_result_t
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    typedef enum logic [1:0] {
        RES_NONE   = 2'd0,
        RES_SINGLE = 2'd1,
        RES_MULTI  = 2'd2
    } scan_kind_t;

    typedef logic [3:0] key_code_t;

    typedef struct packed {
        scan_kind_t kind;
        key_code_t  code;
    } scan_result_t;

    // Index 0 is the rightmost element: column 0 drives 4'b1110.
    localparam logic [NUM_COLS-1:0][NUM_COLS-1:0] COL_DRIVE =
        {4'b0111, 4'b1011, 4'b1101, 4'b1110};

    // Bit i of the snapshot is row (i % 4) of column (i / 4), so the bit
    // position of a lone zero is directly the key code.
    function automatic scan_result_t classify(input logic [NUM_ROWS*NUM_COLS-1:0] rows_n);
        scan_result_t r;
        int unsigned  zeros;
        r.kind = RES_NONE;
        r.code = '0;
        zeros  = 0;
        for (int i = 0; i < NUM_ROWS * NUM_COLS; i++) begin
            if (!rows_n[i]) begin
                zeros++;
                r.code = key_code_t'(i);
            end
        end
        if (zeros == 1) begin
            r.kind = RES_SINGLE;
        end else if (zeros > 1) begin
            r.kind = RES_MULTI;
            r.code = '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: whole-scan debouncer.
//   div_clk       : clock
//   reset         : synchronous active-high reset
//   scan_done     : one-cycle strobe, scan_result holds a fresh scan
//   scan_result   : classification of the scan just completed
//   accepted_kind : kind of the currently accepted (debounced) state
//   press_event   : strobe on the edge where a SINGLE key becomes accepted
//   event_code    : code of that key, valid while press_event is high
import keypad_pkg::*;

module keypad_debounce #(
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic         div_clk,
    input  logic         reset,
    input  logic         scan_done,
    input  scan_result_t scan_result,
    output scan_kind_t   accepted_kind,
    output logic         press_event,
    output key_code_t    event_code
);

    localparam logic [3:0] CNT_MAX = 4'(DEBOUNCE_SCANS);

    scan_result_t last_q, last_d;
    scan_result_t acc_q, acc_d;
    logic [3:0]   stable_q, stable_d;

    // The acceptance test uses the updated count, so with DEBOUNCE_SCANS
    // identical scans the state is accepted on the last scan's evaluation edge.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned, which would otherwise infer a latch.
        last_d      = last_q;
        acc_d       = acc_q;
        stable_d    = stable_q;
        press_event = 1'b0;
        event_code  = last_q.code;
        if (scan_done) begin
            if (scan_result == last_q) begin
                if (stable_q < CNT_MAX) begin
                    stable_d = stable_q + 4'd1;
                end
            end else begin
                last_d   = scan_result;
                stable_d = 4'd1;
            end
            if (stable_d == CNT_MAX && last_d != acc_q) begin
                acc_d       = last_d;
                press_event = (last_d.kind == RES_SINGLE);
                event_code  = last_d.code;
            end
        end
    end

    always_ff @(posedge div_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            last_q   <= '{kind: RES_NONE, code: '0};
            acc_q    <= '{kind: RES_NONE, code: '0};
            stable_q <= '0;
        end else begin
            last_q   <= last_d;
            acc_q    <= acc_d;
            stable_q <= stable_d;
        end
    end

    assign accepted_kind = acc_q.kind;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 passive keypad scanner with debounce and valid/ack holding register.
//   div_clk      : clock, all logic on its rising edge
//   reset        : synchronous active-high reset
//   key_row      : active-low row sense lines
//   key_ack      : consumer acknowledge, clears key_valid
//   key_col      : active-low one-hot column drive
//   key_code     : accepted key code (col_idx*4 + row_idx)
//   key_valid    : a new key code is pending until acknowledged
//   key_held     : a single debounced key is currently down
//   key_overflow : sticky, a press arrived while key_valid was pending
import keypad_pkg::*;

module keypad_scanner #(
    parameter int SETTLE_CYCLES  = 1,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic                div_clk,
    input  logic                reset,
    input  logic [NUM_ROWS-1:0] key_row,
    input  logic                key_ack,
    output logic [NUM_COLS-1:0] key_col,
    output key_code_t           key_code,
    output logic                key_valid,
    output logic                key_held,
    output logic                key_overflow
);

    localparam logic [3:0] SETTLE_MAX = 4'(SETTLE_CYCLES);
    localparam logic [1:0] LAST_COL   = 2'(NUM_COLS - 1);

    logic [1:0]                        col_idx;
    logic [3:0]                        settle_cnt;
    logic                              sample;
    logic [(NUM_COLS-1)*NUM_ROWS-1:0]  row_slots;
    scan_result_t                      scan_result;
    logic                              scan_done;
    scan_kind_t                        accepted_kind;
    logic                              press_event;
    key_code_t                         event_code;

    assign sample = (settle_cnt == SETTLE_MAX);

    // Scan engine. key_col is registered so the column lines never glitch.
    // Column 3 is not stored: its rows are classified together with the
    // slots of columns 0..2 on its own sample edge.
    always_ff @(posedge div_clk) begin
        if (reset) begin
            col_idx     <= '0;
            settle_cnt  <= '0;
            key_col     <= COL_DRIVE[0];
            scan_result <= '{kind: RES_NONE, code: '0};
            scan_done   <= 1'b0;
        end else begin
            scan_done <= 1'b0;
            if (sample) begin
                settle_cnt <= '0;
                col_idx    <= col_idx + 2'd1;
                key_col    <= COL_DRIVE[col_idx + 2'd1];
                if (col_idx == LAST_COL) begin
                    scan_result <= classify({key_row, row_slots});
                    scan_done   <= 1'b1;
                end
            end else begin
                settle_cnt <= settle_cnt + 4'd1;
            end
        end
    end

    // NOTE: the row slots carry no reset; each is rewritten during a scan
    // before the column-3 edge reads it, so its reset value is never observed.
    always_ff @(posedge div_clk) begin
        if (sample && col_idx != LAST_COL) begin
            row_slots[col_idx*NUM_ROWS +: NUM_ROWS] <= key_row;
        end
    end

    keypad_debounce #(
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_debounce (
        .div_clk       (div_clk),
        .reset         (reset),
        .scan_done     (scan_done),
        .scan_result   (scan_result),
        .accepted_kind (accepted_kind),
        .press_event   (press_event),
        .event_code    (event_code)
    );

    assign key_held = (accepted_kind == RES_SINGLE);

    // Holding register: an ack on the event edge frees the slot for the new code.
    always_ff @(posedge div_clk) begin
        if (reset) begin
            key_code     <= '0;
            key_valid    <= 1'b0;
            key_overflow <= 1'b0;
        end else if (press_event) begin
            if (!key_valid || key_ack) begin
                key_code  <= event_code;
                key_valid <= 1'b1;
            end else begin
                key_overflow <= 1'b1;
            end
        end else if (key_ack && key_valid) begin
            key_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

    localparam int SETTLE = 1;
    localparam int DEB    = 3;

    logic        div_clk = 1'b0;
    logic        reset   = 1'b1;
    logic [3:0]  key_row;
    logic        key_ack = 1'b0;
    logic [3:0]  key_col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic        key_overflow;

    logic [15:0] pressed = '0;   // physical keypad: bit k = key k is down
    bit          chk_en  = 1'b0;
    int          errors  = 0;
    int          checks  = 0;

    keypad_scanner #(
        .SETTLE_CYCLES  (SETTLE),
        .DEBOUNCE_SCANS (DEB)
    ) dut (
        .div_clk      (div_clk),
        .reset        (reset),
        .key_row      (key_row),
        .key_ack      (key_ack),
        .key_col      (key_col),
        .key_code     (key_code),
        .key_valid    (key_valid),
        .key_held     (key_held),
        .key_overflow (key_overflow)
    );

    always #5 div_clk = ~div_clk;

    // Passive keypad: a pressed switch shorts its row to the driven column.
    always_comb begin
        key_row = 4'hF;
        for (int c = 0; c < 4; c++) begin
            if (key_col[c] == 1'b0) begin
                for (int r = 0; r < 4; r++) begin
                    if (pressed[c*4+r]) key_row[r] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge div_clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
    endtask

    // ---------------- behavioural reference model ----------------
    // Cycle-count driven: column = (cycles / (SETTLE+1)) mod 4, a scan is a
    // 16-key snapshot counted with $countones, debounce is kept as history.
    int          m_cyc = 0;
    logic [15:0] m_snap = '0;
    int          m_res_kind = 0, m_res_code = 0;
    bit          m_res_ready = 0;
    int          m_last_kind = 0, m_last_code = 0, m_stable = 0;
    int          m_acc_kind = 0, m_acc_code = 0;
    logic [3:0]  m_code = '0;
    bit          m_valid = 0, m_ovf = 0;
    bit          m_ev;
    int          m_ev_code, m_col, m_n;

    always @(posedge div_clk) begin
        if (reset) begin
            m_cyc = 0; m_snap = '0; m_res_ready = 0;
            m_res_kind = 0; m_res_code = 0;
            m_last_kind = 0; m_last_code = 0; m_stable = 0;
            m_acc_kind = 0; m_acc_code = 0;
            m_code = '0; m_valid = 0; m_ovf = 0;
        end else begin
            m_ev = 0;
            m_ev_code = 0;
            if (m_res_ready) begin
                if (m_res_kind == m_last_kind && m_res_code == m_last_code) begin
                    if (m_stable < DEB) m_stable++;
                end else begin
                    m_last_kind = m_res_kind;
                    m_last_code = m_res_code;
                    m_stable = 1;
                end
                if (m_stable == DEB && (m_last_kind != m_acc_kind || m_last_code != m_acc_code)) begin
                    m_acc_kind = m_last_kind;
                    m_acc_code = m_last_code;
                    if (m_acc_kind == 1) begin
                        m_ev = 1;
                        m_ev_code = m_acc_code;
                    end
                end
                m_res_ready = 0;
            end
            if (m_ev) begin
                if (!m_valid || key_ack) begin
                    m_code = 4'(m_ev_code);
                    m_valid = 1;
                end else begin
                    m_ovf = 1;
                end
            end else if (key_ack && m_valid) begin
                m_valid = 0;
            end
            m_col = (m_cyc / (SETTLE + 1)) % 4;
            if (m_cyc % (SETTLE + 1) == SETTLE) begin
                for (int r = 0; r < 4; r++) m_snap[m_col*4+r] = pressed[m_col*4+r];
                if (m_col == 3) begin
                    m_n = $countones(m_snap);
                    m_res_kind = (m_n == 0) ? 0 : (m_n == 1) ? 1 : 2;
                    m_res_code = 0;
                    if (m_n == 1) begin
                        for (int i = 0; i < 16; i++) if (m_snap[i]) m_res_code = i;
                    end
                    m_res_ready = 1;
                end
            end
            m_cyc++;
        end
    end

    logic [3:0] m_exp_col;
    always @(negedge div_clk) begin
        if (chk_en) begin
            m_exp_col = 4'hF ^ (4'b0001 << ((m_cyc / (SETTLE + 1)) % 4));
            check("model key_col", 32'(key_col), 32'(m_exp_col));
            check("model key_code", 32'(key_code), 32'(m_code));
            check("model key_valid", 32'(key_valid), 32'(m_valid));
            check("model key_held", 32'(key_held), 32'(m_acc_kind == 1));
            check("model key_overflow", 32'(key_overflow), 32'(m_ovf));
        end
    end

    // ---------------- stimulus ----------------
    typedef struct {
        string       name;
        logic [15:0] mask;
        logic        exp_valid;
        logic [3:0]  exp_code;
        logic        exp_held;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{"none",        16'h0000, 1'b0, 4'd0,  1'b0};
        vecs[1] = '{"key0",        16'h0001, 1'b1, 4'd0,  1'b1};
        vecs[2] = '{"key6",        16'h0040, 1'b1, 4'd6,  1'b1};
        vecs[3] = '{"key15",       16'h8000, 1'b1, 4'd15, 1'b1};
        vecs[4] = '{"key9",        16'h0200, 1'b1, 4'd9,  1'b1};
        vecs[5] = '{"keys0_5",     16'h0021, 1'b0, 4'd0,  1'b0};
        vecs[6] = '{"keys10_11",   16'h0C00, 1'b0, 4'd0,  1'b0};
        vecs[7] = '{"key12",       16'h1000, 1'b1, 4'd12, 1'b1};

        step(2);
        chk_en = 1'b1;

        // 1: reset state and column sequencing
        do_reset();
        check("rst key_col", 32'(key_col), 32'h0000000E);
        check("rst outputs", {key_code, key_valid, key_held, key_overflow}, 32'h0);
        step(2);
        check("col1 after 2", 32'(key_col), 32'hD);
        step(6);
        check("col0 after 8", 32'(key_col), 32'hE);

        // table: each mask held from a scan start for four scans
        foreach (vecs[i]) begin
            do_reset();
            pressed = vecs[i].mask;
            step(33);
            check({"tbl valid ", vecs[i].name}, 32'(key_valid), 32'(vecs[i].exp_valid));
            check({"tbl code ", vecs[i].name}, 32'(key_code), 32'(vecs[i].exp_code));
            check({"tbl held ", vecs[i].name}, 32'(key_held), 32'(vecs[i].exp_held));
            check({"tbl ovf ", vecs[i].name}, 32'(key_overflow), 32'h0);
            pressed = '0;
        end

        // 2: latency, ack, release
        do_reset();
        pressed = 16'h0040;
        step(24);
        check("t2 valid@24", 32'(key_valid), 32'h0);
        step(1);
        check("t2 valid@25", 32'(key_valid), 32'h1);
        check("t2 code@25", 32'(key_code), 32'd6);
        check("t2 held@25", 32'(key_held), 32'h1);
        key_ack = 1'b1;
        step(1);
        key_ack = 1'b0;
        check("t2 ack clears", 32'(key_valid), 32'h0);
        pressed = '0;
        step(22);
        check("t2 held before release accept", 32'(key_held), 32'h1);
        step(1);
        check("t2 held released", 32'(key_held), 32'h0);
        check("t2 no new event", 32'(key_valid), 32'h0);

        // 3: bounce on alternate scans
        do_reset();
        for (int s = 0; s < 12; s++) begin
            pressed = (s % 2 == 0) ? 16'h0040 : 16'h0000;
            step(8);
        end
        check("t3 bounce valid", 32'(key_valid), 32'h0);
        check("t3 bounce held", 32'(key_held), 32'h0);
        pressed = '0;

        // 4: MULTI then release one key
        do_reset();
        pressed = 16'h0021;
        step(33);
        check("t4 multi valid", 32'(key_valid), 32'h0);
        check("t4 multi held", 32'(key_held), 32'h0);
        pressed = 16'h0020;
        step(23);
        check("t4 valid before", 32'(key_valid), 32'h0);
        step(1);
        check("t4 valid", 32'(key_valid), 32'h1);
        check("t4 code", 32'(key_code), 32'd5);

        // 5: overflow, then ack on the event edge
        do_reset();
        pressed = 16'h0020;
        step(25);
        check("t5 first code", 32'(key_code), 32'd5);
        pressed = '0;
        step(24);
        check("t5 released", 32'(key_held), 32'h0);
        check("t5 ovf clear", 32'(key_overflow), 32'h0);
        pressed = 16'h0200;
        step(24);
        check("t5 code kept", 32'(key_code), 32'd5);
        check("t5 valid kept", 32'(key_valid), 32'h1);
        check("t5 overflow", 32'(key_overflow), 32'h1);
        pressed = '0;
        step(24);
        check("t5 released 2", 32'(key_held), 32'h0);
        pressed = 16'h0200;
        step(23);
        key_ack = 1'b1;
        step(1);
        key_ack = 1'b0;
        check("t5 ack+event code", 32'(key_code), 32'd9);
        check("t5 ack+event valid", 32'(key_valid), 32'h1);
        pressed = '0;

        // 6: reset mid-press
        do_reset();
        pressed = 16'h0008;
        step(30);
        check("t6 pre valid", 32'(key_valid), 32'h1);
        do_reset();
        check("t6 cleared", {key_code, key_valid, key_held, key_overflow}, 32'h0);
        check("t6 col", 32'(key_col), 32'hE);
        step(24);
        check("t6 not yet", 32'(key_valid), 32'h0);
        step(1);
        check("t6 valid again", 32'(key_valid), 32'h1);
        check("t6 code again", 32'(key_code), 32'd3);
        pressed = '0;

        // random segments checked against the model every cycle
        do_reset();
        for (int seg = 0; seg < 120; seg++) begin
            int sel;
            int hold;
            sel  = $urandom_range(0, 99);
            hold = $urandom_range(1, 60);
            if (sel < 10)      pressed = '0;
            else if (sel < 75) pressed = 16'h0001 << $urandom_range(0, 15);
            else               pressed = 16'($urandom);
            for (int c = 0; c < hold; c++) begin
                key_ack = ($urandom_range(0, 7) == 0);
                reset   = ($urandom_range(0, 399) == 0);
                step(1);
            end
        end
        key_ack = 1'b0;
        reset   = 1'b0;
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
